// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the address-phase bundle used by the master-port arbiter.
package ahb_pkg;

  typedef enum logic [1:0] {
    tIDLE   = 2'b00,
    tBUSY   = 2'b01,
    tNONSEQ = 2'b10,
    tSEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    bSINGLE = 3'd0,
    bINCR   = 3'd1,
    bWRAP4  = 3'd2,
    bINCR4  = 3'd3,
    bWRAP8  = 3'd4,
    bINCR8  = 3'd5,
    bWRAP16 = 3'd6,
    bINCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01,
    RETRY = 2'b10,
    SPLIT = 2'b11
  } hresp_e;

  typedef enum logic [1:0] {
    sIdle = 2'd0,
    sAddr = 2'd1,
    sData = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hlock;
  } addr_phase_t;

  // NONSEQ and SEQ both count as a request; IDLE and BUSY do not.
  function automatic logic is_request(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_rr_arbiter2.sv
// Combinational two-way winner select: lock regrant first, then single requester, then tie-break.
module ahb_rr_arbiter2 #(
  parameter int RR_MODE = 1
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       lock_hold,
  input  logic       owner,
  output logic       valid,
  output logic       winner
);

  // NOTE: every output gets a default at the top of the block so no path can infer a latch.
  always_comb begin
    valid  = |req;
    winner = 1'b0;
    if (lock_hold && req[owner]) begin
      winner = owner;
    end else if (req == 2'b01) begin
      winner = 1'b0;
    end else if (req == 2'b10) begin
      winner = 1'b1;
    end else if (req == 2'b11) begin
      winner = (RR_MODE != 0) ? ~last_grant : 1'b0;
    end
  end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Shares one AHB-Lite master port between two mirrored-master requester ports (single transfers only).
module ahb_master_arbiter
  import ahb_pkg::*;
#(
  parameter int RR_MODE        = 1,
  parameter int MAX_LOCK_XFERS = 8
) (
  input  logic        hclk,
  input  logic        reset,

  input  logic [31:0] ahb_m0_haddr,
  input  logic [1:0]  ahb_m0_htrans,
  input  logic        ahb_m0_hwrite,
  input  logic [2:0]  ahb_m0_hsize,
  input  logic [2:0]  ahb_m0_hburst,
  input  logic [3:0]  ahb_m0_hprot,
  input  logic [31:0] ahb_m0_hwdata,
  input  logic        ahb_m0_hlock,
  output logic [31:0] ahb_m0_hrdata,
  output logic        ahb_m0_hready,
  output logic [1:0]  ahb_m0_hresp,

  input  logic [31:0] ahb_m1_haddr,
  input  logic [1:0]  ahb_m1_htrans,
  input  logic        ahb_m1_hwrite,
  input  logic [2:0]  ahb_m1_hsize,
  input  logic [2:0]  ahb_m1_hburst,
  input  logic [3:0]  ahb_m1_hprot,
  input  logic [31:0] ahb_m1_hwdata,
  input  logic        ahb_m1_hlock,
  output logic [31:0] ahb_m1_hrdata,
  output logic        ahb_m1_hready,
  output logic [1:0]  ahb_m1_hresp,

  output logic [31:0] ahb_mst_haddr,
  output logic [1:0]  ahb_mst_htrans,
  output logic        ahb_mst_hwrite,
  output logic [2:0]  ahb_mst_hsize,
  output logic [2:0]  ahb_mst_hburst,
  output logic [3:0]  ahb_mst_hprot,
  output logic [31:0] ahb_mst_hwdata,
  output logic        ahb_mst_hlock,
  input  logic [31:0] ahb_mst_hrdata,
  input  logic        ahb_mst_hready,
  input  logic [1:0]  ahb_mst_hresp,

  output logic        grant,
  output logic        busy
);

  localparam logic [7:0] LOCK_LAST = 8'(MAX_LOCK_XFERS - 1);

  state_e      state, state_nxt;
  htrans_e     htrans_q;
  logic        grant_q;
  logic        last_grant;
  logic        lock_hold;
  logic [7:0]  lock_cnt;
  logic [1:0]  req;
  logic        arb_valid;
  logic        arb_winner;
  logic        owner_hlock;
  addr_phase_t m0_ap, m1_ap, sel_ap;

  assign req = {is_request(ahb_m1_htrans), is_request(ahb_m0_htrans)};

  ahb_rr_arbiter2 #(
    .RR_MODE (RR_MODE)
  ) u_arb (
    .req        (req),
    .last_grant (last_grant),
    .lock_hold  (lock_hold),
    .owner      (grant_q),
    .valid      (arb_valid),
    .winner     (arb_winner)
  );

  assign m0_ap = '{haddr: ahb_m0_haddr, hwrite: ahb_m0_hwrite, hsize: ahb_m0_hsize,
                   hburst: ahb_m0_hburst, hprot: ahb_m0_hprot, hlock: ahb_m0_hlock};
  assign m1_ap = '{haddr: ahb_m1_haddr, hwrite: ahb_m1_hwrite, hsize: ahb_m1_hsize,
                   hburst: ahb_m1_hburst, hprot: ahb_m1_hprot, hlock: ahb_m1_hlock};

  // Address side always follows the grant register; outside sAddr htrans is IDLE so it is ignored.
  assign sel_ap      = grant_q ? m1_ap : m0_ap;
  assign owner_hlock = sel_ap.hlock;

  assign ahb_mst_haddr  = sel_ap.haddr;
  assign ahb_mst_hwrite = sel_ap.hwrite;
  assign ahb_mst_hsize  = sel_ap.hsize;
  assign ahb_mst_hburst = sel_ap.hburst;
  assign ahb_mst_hprot  = sel_ap.hprot;
  assign ahb_mst_hlock  = sel_ap.hlock;
  assign ahb_mst_hwdata = grant_q ? ahb_m1_hwdata : ahb_m0_hwdata;
  assign ahb_mst_htrans = htrans_q;

  assign ahb_m0_hrdata = ahb_mst_hrdata;
  assign ahb_m1_hrdata = ahb_mst_hrdata;

  assign grant = grant_q;
  assign busy  = (state != sIdle);

  always_comb begin
    state_nxt = state;
    unique case (state)
      sIdle:   if (arb_valid)      state_nxt = sAddr;
      sAddr:   if (ahb_mst_hready) state_nxt = sData;
      sData:   if (ahb_mst_hready) state_nxt = sIdle;
      default: state_nxt = sIdle;
    endcase
  end

  // Only the granted port sees the data-phase response; everyone else reads not-ready/OKAY.
  always_comb begin
    ahb_m0_hready = 1'b0;
    ahb_m1_hready = 1'b0;
    ahb_m0_hresp  = OKAY;
    ahb_m1_hresp  = OKAY;
    if (state == sData) begin
      if (grant_q) begin
        ahb_m1_hready = ahb_mst_hready;
        ahb_m1_hresp  = ahb_mst_hresp;
      end else begin
        ahb_m0_hready = ahb_mst_hready;
        ahb_m0_hresp  = ahb_mst_hresp;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge hclk) begin
    if (reset) begin
      state      <= sIdle;
      htrans_q   <= tIDLE;
      grant_q    <= 1'b0;
      last_grant <= 1'b1;
      lock_hold  <= 1'b0;
      lock_cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      unique case (state)
        sIdle: begin
          if (lock_hold && !req[grant_q]) begin
            lock_hold <= 1'b0;
            lock_cnt  <= 8'd0;
          end
          if (arb_valid) begin
            grant_q    <= arb_winner;
            last_grant <= arb_winner;
            htrans_q   <= tNONSEQ;
          end
        end
        sAddr: begin
          if (ahb_mst_hready) htrans_q <= tIDLE;
        end
        sData: begin
          if (ahb_mst_hready) begin
            // A locked owner keeps the bus for at most MAX_LOCK_XFERS back-to-back transfers.
            if (owner_hlock && (lock_cnt < LOCK_LAST)) begin
              lock_hold <= 1'b1;
              lock_cnt  <= lock_cnt + 8'd1;
            end else begin
              lock_hold <= 1'b0;
              lock_cnt  <= 8'd0;
            end
          end
        end
        default: htrans_q <= tIDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Self-checking bench: directed scenarios plus randomized rounds against a transaction-level model.
module tb_ahb_master_arbiter;

  localparam int MAX_LOCK = 8;

  logic        hclk = 1'b0;
  logic        reset;
  logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata;
  logic [1:0]  m0_htrans, m1_htrans;
  logic        m0_hwrite, m1_hwrite, m0_hlock, m1_hlock;
  logic [2:0]  m0_hsize, m1_hsize, m0_hburst, m1_hburst;
  logic [3:0]  m0_hprot, m1_hprot;
  logic [31:0] m0_hrdata, m1_hrdata;
  logic        m0_hready, m1_hready;
  logic [1:0]  m0_hresp, m1_hresp;
  logic [31:0] mst_haddr, mst_hwdata, mst_hrdata;
  logic [1:0]  mst_htrans, mst_hresp;
  logic        mst_hwrite, mst_hlock, mst_hready;
  logic [2:0]  mst_hsize, mst_hburst;
  logic [3:0]  mst_hprot;
  logic        grant, busy;

  logic [31:0] fp_m0_hrdata, fp_m1_hrdata, fp_mst_haddr, fp_mst_hwdata;
  logic        fp_m0_hready, fp_m1_hready, fp_mst_hwrite, fp_mst_hlock, fp_grant, fp_busy;
  logic [1:0]  fp_m0_hresp, fp_m1_hresp, fp_mst_htrans;
  logic [2:0]  fp_mst_hsize, fp_mst_hburst;
  logic [3:0]  fp_mst_hprot;

  int checks   = 0;
  int failures = 0;

  always #5 hclk = ~hclk;

  ahb_master_arbiter #(.RR_MODE(1), .MAX_LOCK_XFERS(MAX_LOCK)) u_dut (
    .hclk(hclk), .reset(reset),
    .ahb_m0_haddr(m0_haddr), .ahb_m0_htrans(m0_htrans), .ahb_m0_hwrite(m0_hwrite),
    .ahb_m0_hsize(m0_hsize), .ahb_m0_hburst(m0_hburst), .ahb_m0_hprot(m0_hprot),
    .ahb_m0_hwdata(m0_hwdata), .ahb_m0_hlock(m0_hlock), .ahb_m0_hrdata(m0_hrdata),
    .ahb_m0_hready(m0_hready), .ahb_m0_hresp(m0_hresp),
    .ahb_m1_haddr(m1_haddr), .ahb_m1_htrans(m1_htrans), .ahb_m1_hwrite(m1_hwrite),
    .ahb_m1_hsize(m1_hsize), .ahb_m1_hburst(m1_hburst), .ahb_m1_hprot(m1_hprot),
    .ahb_m1_hwdata(m1_hwdata), .ahb_m1_hlock(m1_hlock), .ahb_m1_hrdata(m1_hrdata),
    .ahb_m1_hready(m1_hready), .ahb_m1_hresp(m1_hresp),
    .ahb_mst_haddr(mst_haddr), .ahb_mst_htrans(mst_htrans), .ahb_mst_hwrite(mst_hwrite),
    .ahb_mst_hsize(mst_hsize), .ahb_mst_hburst(mst_hburst), .ahb_mst_hprot(mst_hprot),
    .ahb_mst_hwdata(mst_hwdata), .ahb_mst_hlock(mst_hlock), .ahb_mst_hrdata(mst_hrdata),
    .ahb_mst_hready(mst_hready), .ahb_mst_hresp(mst_hresp),
    .grant(grant), .busy(busy)
  );

  // Fixed-priority instance sharing all inputs; only observed in the continuous-request scenario.
  ahb_master_arbiter #(.RR_MODE(0), .MAX_LOCK_XFERS(MAX_LOCK)) u_dut_fp (
    .hclk(hclk), .reset(reset),
    .ahb_m0_haddr(m0_haddr), .ahb_m0_htrans(m0_htrans), .ahb_m0_hwrite(m0_hwrite),
    .ahb_m0_hsize(m0_hsize), .ahb_m0_hburst(m0_hburst), .ahb_m0_hprot(m0_hprot),
    .ahb_m0_hwdata(m0_hwdata), .ahb_m0_hlock(m0_hlock), .ahb_m0_hrdata(fp_m0_hrdata),
    .ahb_m0_hready(fp_m0_hready), .ahb_m0_hresp(fp_m0_hresp),
    .ahb_m1_haddr(m1_haddr), .ahb_m1_htrans(m1_htrans), .ahb_m1_hwrite(m1_hwrite),
    .ahb_m1_hsize(m1_hsize), .ahb_m1_hburst(m1_hburst), .ahb_m1_hprot(m1_hprot),
    .ahb_m1_hwdata(m1_hwdata), .ahb_m1_hlock(m1_hlock), .ahb_m1_hrdata(fp_m1_hrdata),
    .ahb_m1_hready(fp_m1_hready), .ahb_m1_hresp(fp_m1_hresp),
    .ahb_mst_haddr(fp_mst_haddr), .ahb_mst_htrans(fp_mst_htrans), .ahb_mst_hwrite(fp_mst_hwrite),
    .ahb_mst_hsize(fp_mst_hsize), .ahb_mst_hburst(fp_mst_hburst), .ahb_mst_hprot(fp_mst_hprot),
    .ahb_mst_hwdata(fp_mst_hwdata), .ahb_mst_hlock(fp_mst_hlock), .ahb_mst_hrdata(mst_hrdata),
    .ahb_mst_hready(mst_hready), .ahb_mst_hresp(mst_hresp),
    .grant(fp_grant), .busy(fp_busy)
  );

  task automatic tick;
    @(posedge hclk);
    #1;
  endtask

  task automatic drive_port(input int p, input logic [1:0] tr, input logic [31:0] a,
                            input logic [31:0] d, input logic w, input logic l);
    if (p == 0) begin
      m0_htrans = tr; m0_haddr = a; m0_hwdata = d; m0_hwrite = w; m0_hlock = l;
    end else begin
      m1_htrans = tr; m1_haddr = a; m1_hwdata = d; m1_hwrite = w; m1_hlock = l;
    end
  endtask

  task automatic idle_ports;
    drive_port(0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    drive_port(1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    idle_ports();
    mst_hready = 1'b1; mst_hresp = 2'b00; mst_hrdata = 32'h0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_ports();
    m0_hsize = 3'b010; m1_hsize = 3'b010; m0_hburst = 3'b000; m1_hburst = 3'b000;
    m0_hprot = 4'b0011; m1_hprot = 4'b0011;
    mst_hready = 1'b1; mst_hresp = 2'b00; mst_hrdata = 32'h0;
    tick();
    checks++;
    if ({mst_htrans, grant, busy, m0_hready, m1_hready, m0_hresp, m1_hresp} !== 10'b0) begin
      failures++;
      $display("FAIL reset_state got htrans=%b grant=%b busy=%b rdy=%b%b resp=%b/%b exp all zero",
               mst_htrans, grant, busy, m0_hready, m1_hready, m0_hresp, m1_hresp);
    end
    reset = 1'b0;
  endtask

  task automatic test_single;
    do_reset();
    drive_port(0, 2'b10, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 1'b0);
    tick();
    checks++;
    if ({mst_htrans, mst_haddr, mst_hwrite, grant, m0_hready} !== {2'b10, 32'h1000, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL single_addr got htrans=%b haddr=%h hwrite=%b grant=%b rdy=%b exp 10/00001000/1/0/0",
               mst_htrans, mst_haddr, mst_hwrite, grant, m0_hready);
    end
    tick();
    checks++;
    if ({mst_hwdata, m0_hready, m1_hready} !== {32'hDEAD_BEEF, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL single_data got hwdata=%h rdy0=%b rdy1=%b exp deadbeef/1/0",
               mst_hwdata, m0_hready, m1_hready);
    end
    idle_ports();
    tick();
    checks++;
    if ({m0_hready, m1_hready, busy, mst_htrans} !== 5'b0) begin
      failures++;
      $display("FAIL single_done got rdy=%b%b busy=%b htrans=%b exp 0", m0_hready, m1_hready, busy, mst_htrans);
    end
  endtask

  task automatic test_rr_continuous;
    logic [3:0] exp_rdy;
    logic       exp_g;
    do_reset();
    drive_port(0, 2'b10, 32'hA000_0000, 32'h1111_1111, 1'b1, 1'b0);
    drive_port(1, 2'b10, 32'hB000_0000, 32'h2222_2222, 1'b1, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      tick();
      exp_rdy = {(k % 6) == 2, (k % 6) == 5, (k % 3) == 2, 1'b0};
      checks++;
      if ({m0_hready, m1_hready, fp_m0_hready, fp_m1_hready} !== exp_rdy) begin
        failures++;
        $display("FAIL rr_hready cycle=%0d got rr=%b%b fp=%b%b exp %b", k,
                 m0_hready, m1_hready, fp_m0_hready, fp_m1_hready, exp_rdy);
      end
      if ((k % 3) == 1) begin
        exp_g = ((k % 6) == 4);
        checks++;
        if ({grant, mst_haddr, fp_grant, fp_mst_haddr} !==
            {exp_g, exp_g ? 32'hB000_0000 : 32'hA000_0000, 1'b0, 32'hA000_0000}) begin
          failures++;
          $display("FAIL rr_grant cycle=%0d got grant=%b haddr=%h fp_grant=%b exp grant=%b",
                   k, grant, mst_haddr, fp_grant, exp_g);
        end
      end
    end
    idle_ports();
    tick();
  endtask

  task automatic test_wait_states;
    do_reset();
    drive_port(1, 2'b10, 32'h0000_2000, 32'h0, 1'b0, 1'b0);
    tick();
    checks++;
    if ({grant, mst_htrans, mst_hwrite} !== 4'b1100) begin
      failures++;
      $display("FAIL wait_addr got grant=%b htrans=%b hwrite=%b exp 1/10/0", grant, mst_htrans, mst_hwrite);
    end
    tick();
    for (int d = 0; d < 4; d++) begin
      mst_hready = (d == 3);
      mst_hrdata = (d == 3) ? 32'h1234_5678 : 32'h0;
      #1;
      checks++;
      if ({m1_hready, m0_hready} !== {d == 3, 1'b0}) begin
        failures++;
        $display("FAIL wait_hready d=%0d got m1=%b m0=%b exp m1=%b", d, m1_hready, m0_hready, d == 3);
      end
      if (d == 3) begin
        checks++;
        if (m1_hrdata !== 32'h1234_5678) begin
          failures++;
          $display("FAIL wait_rdata got %h exp 12345678", m1_hrdata);
        end
      end else begin
        tick();
      end
    end
    idle_ports();
    tick();
    mst_hrdata = 32'h0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL wait_idle got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_error;
    do_reset();
    drive_port(0, 2'b10, 32'h0000_3000, 32'hCAFE_0000, 1'b1, 1'b0);
    drive_port(1, 2'b10, 32'h0000_4000, 32'hCAFE_0001, 1'b1, 1'b0);
    tick();
    checks++;
    if (grant !== 1'b0) begin
      failures++;
      $display("FAIL err_first_tie got grant=%b exp 0", grant);
    end
    tick();
    for (int c = 0; c < 2; c++) begin
      mst_hready = (c == 1);
      mst_hresp  = 2'b01;
      #1;
      checks++;
      if ({m0_hresp, m0_hready, m1_hresp, m1_hready} !== {2'b01, c == 1, 2'b00, 1'b0}) begin
        failures++;
        $display("FAIL err_resp c=%0d got m0=%b/%b m1=%b/%b exp 01/%b 00/0",
                 c, m0_hresp, m0_hready, m1_hresp, m1_hready, c == 1);
      end
      if (c == 0) tick();
    end
    drive_port(0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    mst_hresp = 2'b00;
    tick();
    checks++;
    if ({grant, mst_htrans} !== 3'b110) begin
      failures++;
      $display("FAIL err_next_rr got grant=%b htrans=%b exp 1/10", grant, mst_htrans);
    end
    tick();
    checks++;
    if ({m1_hready, m1_hresp} !== 3'b100) begin
      failures++;
      $display("FAIL err_m1_okay got rdy=%b resp=%b exp 1/00", m1_hready, m1_hresp);
    end
    idle_ports();
    tick();
  endtask

  task automatic test_lock_limit;
    int exp_w;
    do_reset();
    drive_port(1, 2'b10, 32'h0000_5000, 32'h5555_0000, 1'b1, 1'b1);
    for (int r = 0; r < 10; r++) begin
      drive_port(0, (r > 0) ? 2'b10 : 2'b00, 32'h0000_6000, 32'h6666_0000, 1'b1, 1'b0);
      exp_w = (r < MAX_LOCK || r == MAX_LOCK + 1) ? 1 : 0;
      tick();
      checks++;
      if ({grant, mst_htrans} !== {1'(exp_w), 2'b10}) begin
        failures++;
        $display("FAIL lock_grant round=%0d got grant=%b htrans=%b exp %0d/10", r, grant, mst_htrans, exp_w);
      end
      tick();
      checks++;
      if ({m1_hready, m0_hready} !== {exp_w == 1, exp_w == 0}) begin
        failures++;
        $display("FAIL lock_hready round=%0d got m1=%b m0=%b exp owner %0d", r, m1_hready, m0_hready, exp_w);
      end
      tick();
    end
    idle_ports();
    tick();
  endtask

  task automatic test_reset_mid;
    do_reset();
    drive_port(0, 2'b10, 32'h0000_7000, 32'h7777_0000, 1'b1, 1'b0);
    tick();
    tick();
    mst_hready = 1'b0;
    reset = 1'b1;
    tick();
    checks++;
    if ({mst_htrans, m0_hready, m1_hready, grant, busy} !== 6'b0) begin
      failures++;
      $display("FAIL rst_mid got htrans=%b rdy=%b%b grant=%b busy=%b exp 0",
               mst_htrans, m0_hready, m1_hready, grant, busy);
    end
    reset = 1'b0;
    mst_hready = 1'b1;
    drive_port(1, 2'b10, 32'h0000_8000, 32'h8888_0000, 1'b1, 1'b0);
    tick();
    checks++;
    if ({grant, mst_htrans} !== 3'b010) begin
      failures++;
      $display("FAIL rst_first_tie got grant=%b htrans=%b exp 0/10", grant, mst_htrans);
    end
    tick();
    idle_ports();
    tick();
  endtask

  task automatic test_random(input int rounds);
    logic [1:0]  rq;
    logic [31:0] addr [2];
    logic [31:0] wdat [2];
    logic        wr   [2];
    logic        lk   [2];
    logic        m_last, m_hold, m_owner;
    int          m_cnt, w, aw, dw;
    logic [1:0]  rsp;
    logic [31:0] rd;
    do_reset();
    m_last = 1'b1; m_hold = 1'b0; m_owner = 1'b0; m_cnt = 0;
    for (int n = 0; n < rounds; n++) begin
      rq = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        addr[p] = $urandom; wdat[p] = $urandom;
        wr[p] = 1'($urandom_range(0, 1)); lk[p] = ($urandom_range(0, 2) != 0);
        drive_port(p, {rq[p], 1'($urandom_range(0, 1))}, addr[p], wdat[p], wr[p], lk[p]);
      end
      if (m_hold && !rq[m_owner]) begin
        m_hold = 1'b0; m_cnt = 0;
      end
      tick();
      if (rq == 2'b00) begin
        checks++;
        if ({busy, mst_htrans} !== 3'b000) begin
          failures++;
          $display("FAIL rnd_noreq n=%0d got busy=%b htrans=%b exp 0", n, busy, mst_htrans);
        end
        continue;
      end
      if (m_hold && rq[m_owner]) w = int'(m_owner);
      else if (rq == 2'b11) w = m_last ? 0 : 1;
      else w = rq[1] ? 1 : 0;
      m_last = 1'(w); m_owner = 1'(w);
      checks++;
      if ({grant, mst_htrans, mst_haddr, mst_hwrite} !== {1'(w), 2'b10, addr[w], wr[w]}) begin
        failures++;
        $display("FAIL rnd_grant n=%0d got grant=%b htrans=%b haddr=%h exp grant=%0d haddr=%h",
                 n, grant, mst_htrans, mst_haddr, w, addr[w]);
      end
      aw = $urandom_range(0, 2);
      for (int a = 0; a < aw; a++) begin
        mst_hready = 1'b0;
        tick();
        checks++;
        if ({mst_htrans, busy, m0_hready, m1_hready} !== 5'b10100) begin
          failures++;
          $display("FAIL rnd_addr_wait n=%0d got htrans=%b busy=%b rdy=%b%b exp 10/1/00",
                   n, mst_htrans, busy, m0_hready, m1_hready);
        end
      end
      mst_hready = 1'b1;
      tick();
      dw = $urandom_range(0, 2);
      for (int d = 0; d <= dw; d++) begin
        rsp = 2'($urandom_range(0, 3));
        rd  = $urandom;
        mst_hready = (d == dw); mst_hresp = rsp; mst_hrdata = rd;
        #1;
        checks++;
        if ({m1_hready, m0_hready, m1_hresp, m0_hresp, mst_hwdata, m0_hrdata, m1_hrdata} !==
            {(w == 1) && (d == dw), (w == 0) && (d == dw), (w == 1) ? rsp : 2'b00,
             (w == 0) ? rsp : 2'b00, wdat[w], rd, rd}) begin
          failures++;
          $display("FAIL rnd_data n=%0d d=%0d got rdy=%b%b resp=%b/%b hwdata=%h exp owner=%0d resp=%b hwdata=%h",
                   n, d, m1_hready, m0_hready, m1_hresp, m0_hresp, mst_hwdata, w, rsp, wdat[w]);
        end
        if (d < dw) tick();
      end
      if (lk[w] && m_cnt < MAX_LOCK - 1) begin
        m_hold = 1'b1; m_cnt++;
      end else begin
        m_hold = 1'b0; m_cnt = 0;
      end
      tick();
      mst_hready = 1'b1; mst_hresp = 2'b00;
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL rnd_return n=%0d got busy=%b exp 0", n, busy);
      end
    end
    idle_ports();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_rr_continuous();
    test_wait_states();
    test_error();
    test_lock_limit();
    test_reset_mid();
    test_random(200);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
